ppfifo_rd_arbiter: RTL and testbench

PPFIFO_RD_ARBITER -- requirements
Module: ppfifo_rd_arbiter

---
 rtl/ppfifo_rd_arbiter_pkg.sv | 16 +
 rtl/ppfifo_rd_arbiter_if.sv | 32 +++
 rtl/ppfifo_rd_arbiter_rr_pick.sv | 35 +++
 rtl/ppfifo_rd_arbiter.sv | 125 ++++++++++++
 tb/tb_ppfifo_rd_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ppfifo_rd_arbiter_pkg.sv
// rtl/ppfifo_rd_arbiter_pkg.sv - shared types and constants for the ping-pong FIFO read arbiter
package ppfifo_arb_pkg;

    localparam int SIZE_W    = 24;
    localparam int MAX_PORTS = 8;
    localparam int GNT_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACTIVATE = 3'd1,
        ST_OFFER    = 3'd2,
        ST_BUSY     = 3'd3,
        ST_RELEASE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/ppfifo_rd_arbiter_if.sv
// rtl/ppfifo_rd_arbiter_if.sv - upstream FIFO and consumer port bundle for the read arbiter
interface ppfifo_rd_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8
);
    import ppfifo_arb_pkg::*;

    logic                  i_rd_rdy;
    logic                  o_rd_act;
    logic [SIZE_W-1:0]     i_rd_size;
    logic                  o_rd_stb;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic [NUM_PORTS-1:0]  i_req;
    logic [NUM_PORTS-1:0]  o_p_rdy;
    logic [NUM_PORTS-1:0]  i_p_act;
    logic [SIZE_W-1:0]     o_p_size;
    logic [NUM_PORTS-1:0]  i_p_stb;
    logic [DATA_WIDTH-1:0] o_p_data;
    logic [GNT_W-1:0]      o_gnt_id;
    logic                  o_overrun;

    modport master (
        input  i_rd_rdy, i_rd_size, i_rd_data, i_req, i_p_act, i_p_stb,
        output o_rd_act, o_rd_stb, o_p_rdy, o_p_size, o_p_data, o_gnt_id, o_overrun
    );

    modport slave (
        output i_rd_rdy, i_rd_size, i_rd_data, i_req, i_p_act, i_p_stb,
        input  o_rd_act, o_rd_stb, o_p_rdy, o_p_size, o_p_data, o_gnt_id, o_overrun
    );

endinterface

// File: rtl/ppfifo_rd_arbiter_rr_pick.sv
// rtl/ppfifo_rd_arbiter_rr_pick.sv - combinational round-robin pick starting after the last grant
module rr_pick
    import ppfifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [GNT_W-1:0] last_i,
    output logic [N-1:0]     onehot_o,
    output logic [GNT_W-1:0] idx_o,
    output logic             valid_o
);

    logic [MAX_PORTS-1:0] req_pad;
    logic [GNT_W-1:0]     cand;

    assign req_pad = MAX_PORTS'(req_i);

    // Visit last+1 .. last+N so the previous winner is considered last.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand = GNT_W'((int'(last_i) + i) % N);
            if (!valid_o && req_pad[cand]) begin
                valid_o  = 1'b1;
                idx_o    = cand;
                onehot_o = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/ppfifo_rd_arbiter.sv
// rtl/ppfifo_rd_arbiter.sv - shares one ping-pong FIFO read side among consumer ports block by block
// Optional offer timeout: PPFIFO_ARB_TIMEOUT_EN
module ppfifo_rd_arbiter
    import ppfifo_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic clk,
    input  logic rst_n,
    ppfifo_rd_arbiter_if.master bus
);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS || DATA_WIDTH < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("ppfifo_rd_arbiter: parameter out of range");
    end

    arb_state_t           state_q, state_d;
    logic [GNT_W-1:0]     gnt_q, last_q, pick_idx;
    logic [NUM_PORTS-1:0] gnt_oh_q, pick_oh;
    logic                 pick_valid;
    logic [SIZE_W-1:0]    size_q, cnt_q;
    logic                 overrun_q;
    logic [MAX_PORTS-1:0] act_pad, stb_pad;
    logic                 act_g, busy_stb, fwd, over, rd_act, tmo_hit;
    logic [NUM_PORTS-1:0] p_rdy;

`ifdef PPFIFO_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign act_pad  = MAX_PORTS'(bus.i_p_act);
    assign stb_pad  = MAX_PORTS'(bus.i_p_stb);
    assign act_g    = act_pad[gnt_q];

    rr_pick #(.N(NUM_PORTS)) u_pick (
        .req_i    (bus.i_req),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.i_rd_rdy && pick_valid) state_d = ST_ACTIVATE;
            ST_ACTIVATE: state_d = ST_OFFER;
            ST_OFFER:    if (act_g) state_d = ST_BUSY;
                         else if (tmo_hit) state_d = ST_RELEASE;
            ST_BUSY:     if (!act_g) state_d = ST_RELEASE;
            ST_RELEASE:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Strobes past the block size are swallowed and flagged, never forwarded.
    always_comb begin
        rd_act   = 1'b0;
        p_rdy    = '0;
        busy_stb = 1'b0;
        case (state_q)
            ST_ACTIVATE: rd_act = 1'b1;
            ST_OFFER: begin
                rd_act = 1'b1;
                p_rdy  = gnt_oh_q;
            end
            ST_BUSY: begin
                rd_act   = 1'b1;
                busy_stb = stb_pad[gnt_q];
            end
            default: ;
        endcase
        fwd  = busy_stb && (cnt_q < size_q);
        over = busy_stb && !(cnt_q < size_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            gnt_oh_q  <= '0;
            last_q    <= GNT_W'(NUM_PORTS - 1);
            size_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
`ifdef PPFIFO_ARB_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            if (state_q == ST_IDLE && state_d == ST_ACTIVATE) begin
                gnt_q    <= pick_idx;
                gnt_oh_q <= pick_oh;
            end
            if (state_q == ST_ACTIVATE) size_q <= bus.i_rd_size;
            if (fwd) cnt_q <= cnt_q + 1'b1;
            if (over) overrun_q <= 1'b1;
            if (state_q == ST_RELEASE) begin
                last_q <= gnt_q;
                cnt_q  <= '0;
            end
`ifdef PPFIFO_ARB_TIMEOUT_EN
            tmo_q <= (state_q == ST_OFFER) ? tmo_q + 1'b1 : '0;
`endif
        end
    end

    assign bus.o_rd_act  = rd_act;
    assign bus.o_rd_stb  = fwd;
    assign bus.o_p_rdy   = p_rdy;
    assign bus.o_p_size  = size_q;
    assign bus.o_p_data  = bus.i_rd_data;
    assign bus.o_gnt_id  = gnt_q;
    assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_ppfifo_rd_arbiter.sv
// tb/tb_ppfifo_rd_arbiter.sv - table-driven and sequence checks of the read arbiter with a data scoreboard
module tb_ppfifo_rd_arbiter;
    import ppfifo_arb_pkg::*;

    localparam int NP = 4;
    localparam int DW = 8;
`ifdef PPFIFO_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ppfifo_rd_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    ppfifo_rd_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int total = 0;
    int bad = 0;
    int fwd_seen = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] sb_exp;

    typedef struct {
        logic [NP-1:0] req;
        logic [23:0]   size;
        int            nstb;
        int            drop;
        bit            req_drop;
        int            exp_g;
        int            exp_fwd;
        bit            exp_ovr;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_rd_stb === 1'b1) begin
            fwd_seen++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_stb: got forwarded strobe expected none");
            end else begin
                sb_exp = sb_q.pop_front();
                check("p_data", 32'(bus.o_p_data), 32'(sb_exp));
            end
        end
    end

    task automatic do_block(input vec_t v);
        int  g, mcnt, base;
        bit  seen;
        logic [DW-1:0] d;
        g = v.exp_g;
        mcnt = 0;
        base = fwd_seen;
        bus.i_rd_rdy  = 1'b1;
        bus.i_rd_size = v.size;
        bus.i_req     = v.req;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (bus.o_p_rdy != '0) seen = 1'b1;
        end
        check("offer_seen", 32'(seen), 1);
        check("p_rdy", 32'(bus.o_p_rdy), 32'(1 << g));
        check("gnt_id", 32'(bus.o_gnt_id), 32'(g));
        check("p_size", 32'(bus.o_p_size), 32'(v.size));
        check("offer_rd_act", 32'(bus.o_rd_act), 1);
        if (v.req_drop) bus.i_req = '0;
        bus.i_p_act = NP'(1) << g;
        step();
        for (int k = 0; k < v.nstb; k++) begin
            if (k == v.drop) break;
            d = DW'($urandom);
            bus.i_rd_data = d;
            bus.i_p_stb = (NP'(1) << g) | (NP'($urandom) & ~(NP'(1) << g));
            if (mcnt < int'(v.size)) begin
                sb_q.push_back(d);
                mcnt++;
            end
            step();
        end
        bus.i_p_stb = '0;
        bus.i_p_act = '0;
        step();
        check("release_rd_act", 32'(bus.o_rd_act), 0);
        step();
        check("idle_rd_act", 32'(bus.o_rd_act), 0);
        check("idle_p_rdy", 32'(bus.o_p_rdy), 0);
        check("fwd_count", 32'(fwd_seen - base), 32'(v.exp_fwd));
        check("overrun", 32'(bus.o_overrun), 32'(v.exp_ovr));
        check("sb_drained", 32'(sb_q.size()), 0);
        bus.i_rd_rdy = 1'b0;
        bus.i_req    = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        logic [DW-1:0] d;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{req:4'b1111, size:24'd4, nstb:4, drop:-1, req_drop:1'b0,
                       exp_g:i % 4, exp_fwd:4, exp_ovr:1'b0};
        tbl[8]  = '{req:4'b0100, size:24'd16, nstb:16, drop:-1, req_drop:1'b1, exp_g:2, exp_fwd:16, exp_ovr:1'b0};
        tbl[9]  = '{req:4'b0011, size:24'd10, nstb:10, drop:5,  req_drop:1'b0, exp_g:0, exp_fwd:5,  exp_ovr:1'b0};
        tbl[10] = '{req:4'b0011, size:24'd6,  nstb:6,  drop:-1, req_drop:1'b0, exp_g:1, exp_fwd:6,  exp_ovr:1'b0};
        tbl[11] = '{req:4'b1010, size:24'd5,  nstb:3,  drop:-1, req_drop:1'b0, exp_g:3, exp_fwd:3,  exp_ovr:1'b0};
        tbl[12] = '{req:4'b0010, size:24'd16, nstb:20, drop:-1, req_drop:1'b0, exp_g:1, exp_fwd:16, exp_ovr:1'b1};
        tbl[13] = '{req:4'b0001, size:24'd0,  nstb:2,  drop:-1, req_drop:1'b0, exp_g:0, exp_fwd:0,  exp_ovr:1'b1};

        bus.i_rd_rdy = 1'b0; bus.i_rd_size = '0; bus.i_rd_data = '0;
        bus.i_req = '0; bus.i_p_act = '0; bus.i_p_stb = '0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_rd_act", 32'(bus.o_rd_act), 0);
        check("rst_rd_stb", 32'(bus.o_rd_stb), 0);
        check("rst_p_rdy", 32'(bus.o_p_rdy), 0);
        check("rst_p_size", 32'(bus.o_p_size), 0);
        check("rst_gnt_id", 32'(bus.o_gnt_id), 0);
        check("rst_overrun", 32'(bus.o_overrun), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) do_block(tbl[i]);

        repeat (4) step();
        check("overrun_sticky", 32'(bus.o_overrun), 1);

        // Reset in the middle of a block with a strobe pending.
        bus.i_rd_rdy = 1'b1; bus.i_rd_size = 24'd16; bus.i_req = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (bus.o_p_rdy != '0) seen = 1'b1;
        end
        check("mid_offer_p_rdy", 32'(bus.o_p_rdy), 32'h2);
        bus.i_p_act = 4'b0010;
        step();
        for (int k = 0; k < 7; k++) begin
            d = DW'($urandom);
            bus.i_rd_data = d;
            bus.i_p_stb = 4'b0010;
            sb_q.push_back(d);
            step();
        end
        check("mid_busy_rd_act", 32'(bus.o_rd_act), 1);
        bus.i_p_stb = 4'b0010;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_act", 32'(bus.o_rd_act), 0);
        check("mid_rst_rd_stb", 32'(bus.o_rd_stb), 0);
        check("mid_rst_p_rdy", 32'(bus.o_p_rdy), 0);
        check("mid_rst_overrun", 32'(bus.o_overrun), 0);
        check("mid_rst_sb", 32'(sb_q.size()), 0);
        bus.i_p_stb = '0; bus.i_p_act = '0; bus.i_req = '0; bus.i_rd_rdy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        do_block('{req:4'b1111, size:24'd3, nstb:3, drop:-1, req_drop:1'b0, exp_g:0, exp_fwd:3, exp_ovr:1'b0});

`ifdef PPFIFO_ARB_TIMEOUT_EN
        bus.i_rd_rdy = 1'b1; bus.i_rd_size = 24'd4; bus.i_req = 4'b1000;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (bus.o_p_rdy != '0) seen = 1'b1;
        end
        check("tmo_p_rdy", 32'(bus.o_p_rdy), 32'h8);
        n = seen ? 1 : 0;
        for (int k = 0; k < 50 && seen; k++) begin
            step();
            if (bus.o_p_rdy != '0) n++;
            else break;
        end
        check("tmo_offer_cycles", 32'(n), 8);
        check("tmo_release_rd_act", 32'(bus.o_rd_act), 0);
        bus.i_req = '0; bus.i_rd_rdy = 1'b0;
        step();
        do_block('{req:4'b1111, size:24'd2, nstb:2, drop:-1, req_drop:1'b0, exp_g:0, exp_fwd:2, exp_ovr:1'b0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
